// File: rtl/bist_pkg.sv
// ============================================================================
// Module      : bist_pkg
// Description : Shared types, tap constants and status/config field indices
//               for the BIST run controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    APPLY   = 3'd2,
    CLK_HI  = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Feedback taps: LFSR x^4+x^3+1 style (bits 3,2); MISR bits 7,5,4,3
  localparam logic [3:0] LFSR_TAPS = 4'b1100;
  localparam logic [7:0] MISR_TAPS = 8'b1011_1000;

  localparam int unsigned STAT_BUSY  = 15;
  localparam int unsigned STAT_DONE  = 14;
  localparam int unsigned STAT_PASS  = 13;
  localparam int unsigned STAT_ABORT = 12;

  localparam int unsigned CFG_N_MSB   = 15;
  localparam int unsigned CFG_N_LSB   = 8;
  localparam int unsigned CFG_EXP_MSB = 7;
  localparam int unsigned CFG_EXP_LSB = 0;

  function automatic logic [3:0] lfsr_next(input logic [3:0] l);
    return {l[2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] misr_next(input logic [7:0] m, input logic [3:0] y);
    return {m[6:0], ^(m & MISR_TAPS)} ^ {4'b0000, y};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bist_run_controller_if.sv
// ============================================================================
// Module      : bist_run_controller_if
// Description : TAP-side config/status and logic-side pattern/response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bist_run_controller_if;
  logic        BIST_clk_en;
  logic [15:0] To_BIST_reg;
  logic [3:0]  BIST_from_logic_Y;
  logic [3:0]  BIST_to_logic_X;
  logic        BIST_to_logic_res;
  logic        BIST_to_logic_clk;
  logic [15:0] From_BIST_reg;

  modport slave (
    input  BIST_clk_en, To_BIST_reg, BIST_from_logic_Y,
    output BIST_to_logic_X, BIST_to_logic_res, BIST_to_logic_clk, From_BIST_reg
  );

  modport master (
    output BIST_clk_en, To_BIST_reg, BIST_from_logic_Y,
    input  BIST_to_logic_X, BIST_to_logic_res, BIST_to_logic_clk, From_BIST_reg
  );
endinterface

`default_nettype wire

// File: rtl/bist_sync.sv
// ============================================================================
// Module      : bist_sync
// Description : Two-flop level synchronizer with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/bist_run_controller.sv
// ============================================================================
// Module      : bist_run_controller
// Description : Runs one LFSR/MISR BIST pass over the function module.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_run_controller
  import bist_pkg::*;
#(
  parameter logic [3:0]  LFSR_SEED  = 4'b0001,
  parameter int unsigned RES_CYCLES = 4
) (
  input  logic                 clk_50MHz,
  input  logic                 BIST_res,
  bist_run_controller_if.slave bus
);

  localparam logic [3:0] RCNT_INIT = 4'(RES_CYCLES - 1);

  logic   en_sync, en_prev_q, start;
  state_e state_q, state_d;
  logic [7:0] exp_q, exp_d;
  logic [3:0] lfsr_q, lfsr_d;
  logic [7:0] misr_q, misr_d;
  logic [8:0] rem_q, rem_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       done_q, done_d, pass_q, pass_d, abort_q, abort_d;
  logic [3:0] x_q, x_d;
  logic       res_q, res_d, clk_q, clk_d;
  logic       running;
  logic [7:0] misr_nxt, n_cfg;
  logic [3:0] lfsr_nxt;

  bist_sync #(.WIDTH(1)) u_sync (
    .clk (clk_50MHz),
    .rst (BIST_res),
    .d_i (bus.BIST_clk_en),
    .q_o (en_sync)
  );

  assign start    = en_sync & ~en_prev_q;
  assign running  = (state_q == RESET) || (state_q == APPLY) ||
                    (state_q == CLK_HI) || (state_q == CAPTURE);
  assign misr_nxt = misr_next(misr_q, bus.BIST_from_logic_Y);
  assign lfsr_nxt = lfsr_next(lfsr_q);
  assign n_cfg    = bus.To_BIST_reg[CFG_N_MSB:CFG_N_LSB];

  // Logic-side outputs are registered versions of the next-state decode
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    rem_d   = rem_q;
    rcnt_d  = rcnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    abort_d = abort_q;
    x_d     = 4'b0000;
    res_d   = 1'b0;
    clk_d   = 1'b0;
    if (running && !en_sync) begin
      state_d = IDLE;
      abort_d = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RESET;
            exp_d   = bus.To_BIST_reg[CFG_EXP_MSB:CFG_EXP_LSB];
            lfsr_d  = LFSR_SEED;
            misr_d  = 8'h00;
            abort_d = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            rem_d   = (n_cfg == 8'h00) ? 9'd256 : {1'b0, n_cfg};
            rcnt_d  = RCNT_INIT;
            res_d   = 1'b1;
          end
        end
        RESET: begin
          if (rcnt_q == 4'd0) begin
            state_d = APPLY;
            x_d     = lfsr_q;
          end else begin
            rcnt_d = rcnt_q - 4'd1;
            res_d  = 1'b1;
          end
        end
        APPLY: begin
          state_d = CLK_HI;
          x_d     = lfsr_q;
          clk_d   = 1'b1;
        end
        CLK_HI: begin
          state_d = CAPTURE;
          x_d     = lfsr_q;
        end
        CAPTURE: begin
          misr_d = misr_nxt;
          lfsr_d = lfsr_nxt;
          rem_d  = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (misr_nxt == exp_q);
          end else begin
            state_d = APPLY;
            x_d     = lfsr_nxt;
          end
        end
        DONE: begin
          if (!en_sync) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (BIST_res) begin
      en_prev_q <= 1'b0;
      state_q   <= IDLE;
      exp_q     <= 8'h00;
      lfsr_q    <= LFSR_SEED;
      misr_q    <= 8'h00;
      rem_q     <= 9'd0;
      rcnt_q    <= 4'd0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      abort_q   <= 1'b0;
      x_q       <= 4'b0000;
      res_q     <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      en_prev_q <= en_sync;
      state_q   <= state_d;
      exp_q     <= exp_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      rem_q     <= rem_d;
      rcnt_q    <= rcnt_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      abort_q   <= abort_d;
      x_q       <= x_d;
      res_q     <= res_d;
      clk_q     <= clk_d;
    end
  end

  assign bus.BIST_to_logic_X   = x_q;
  assign bus.BIST_to_logic_res = res_q;
  assign bus.BIST_to_logic_clk = clk_q;
  assign bus.From_BIST_reg     = {running, done_q, pass_q, abort_q, 4'b0000, misr_q};

endmodule

`default_nettype wire

// File: tb/tb_bist_run_controller.sv
// ============================================================================
// Module      : tb_bist_run_controller
// Description : Scoreboard bench for bist_run_controller with a pattern-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_run_controller;

  localparam logic [3:0] SEED = 4'b0001;
  localparam int         RESC = 4;

  logic clk_50MHz = 1'b0;
  logic BIST_res  = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   y_mode = 0;
  logic [3:0] y_key = 4'h0;

  logic [3:0]  q_x[$];
  logic [15:0] q_status[$];
  int          q_lat[$];

  bist_run_controller_if bus ();

  bist_run_controller #(.LFSR_SEED(SEED), .RES_CYCLES(RESC)) dut (
    .clk_50MHz (clk_50MHz),
    .BIST_res  (BIST_res),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  function automatic logic [3:0] resp(input int mode, input logic [3:0] key, input logic [3:0] x);
    if (mode == 0) return x;
    if (mode == 1) return 4'h0;
    return x ^ key;
  endfunction

  assign bus.BIST_from_logic_Y = resp(y_mode, y_key, bus.BIST_to_logic_X);

  // Reference rules: pattern generator and signature compactor at value level
  function automatic logic [3:0] ref_lfsr(input logic [3:0] l);
    int v;
    v = int'(l);
    return 4'(((v * 2) % 16) + (((v >> 3) ^ (v >> 2)) & 1));
  endfunction

  function automatic logic [7:0] ref_misr(input logic [7:0] m, input logic [3:0] y);
    int v, fb;
    v  = int'(m);
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return 8'((((v * 2) % 256) + fb) ^ int'(y));
  endfunction

  // Monitor: pops expectations whenever the DUT shows a clock pulse, a reset
  // window end, or a done/abort status rise.
  logic prev_clk = 1'b0, prev_res = 1'b0, prev_fin = 1'b0;
  int   res_cnt = 0, lat_cnt = 0;
  always @(negedge clk_50MHz) begin
    if (!BIST_res) begin
      if (bus.BIST_to_logic_clk) begin
        tests++;
        if (prev_clk) begin fails++; $display("FAIL clk_width: got high two cycles, required one"); end
        tests++;
        if (bus.From_BIST_reg[15] !== 1'b1) begin fails++; $display("FAIL busy_in_pulse: got %b required 1", bus.From_BIST_reg[15]); end
        tests++;
        if (q_x.size() == 0) begin
          fails++; $display("FAIL unexpected_pulse: got pulse X=%h required none", bus.BIST_to_logic_X);
        end else begin
          logic [3:0] ex;
          ex = q_x.pop_front();
          if (bus.BIST_to_logic_X !== ex) begin fails++; $display("FAIL pattern: got %h required %h", bus.BIST_to_logic_X, ex); end
        end
      end
      if (bus.BIST_to_logic_res) begin
        if (!prev_res) begin res_cnt = 0; lat_cnt = -1; end
        res_cnt++;
      end else if (prev_res) begin
        tests++;
        if (res_cnt != RESC) begin fails++; $display("FAIL res_len: got %0d required %0d", res_cnt, RESC); end
      end
      lat_cnt++;
      if ((bus.From_BIST_reg[14] | bus.From_BIST_reg[12]) && !prev_fin) begin
        tests++;
        if (q_status.size() == 0) begin
          fails++; $display("FAIL unexpected_status: got %h required none", bus.From_BIST_reg);
        end else begin
          logic [15:0] es;
          es = q_status.pop_front();
          if (bus.From_BIST_reg !== es) begin fails++; $display("FAIL status: got %h required %h", bus.From_BIST_reg, es); end
        end
        if (bus.From_BIST_reg[14]) begin
          tests++;
          if (q_lat.size() == 0) begin
            fails++; $display("FAIL unexpected_done: got latency %0d required none", lat_cnt);
          end else begin
            int el;
            el = q_lat.pop_front();
            if (lat_cnt != el) begin fails++; $display("FAIL done_latency: got %0d required %0d", lat_cnt, el); end
          end
        end
      end
      prev_fin = bus.From_BIST_reg[14] | bus.From_BIST_reg[12];
    end else begin
      prev_fin = 1'b0;
    end
    prev_clk = bus.BIST_to_logic_clk;
    prev_res = bus.BIST_to_logic_res;
  end

  task automatic check_idle_outputs(input string name);
    tests++;
    if ({bus.BIST_to_logic_X, bus.BIST_to_logic_res, bus.BIST_to_logic_clk} !== 6'b0) begin
      fails++;
      $display("FAIL %s: got X=%h res=%b clk=%b required all 0", name,
               bus.BIST_to_logic_X, bus.BIST_to_logic_res, bus.BIST_to_logic_clk);
    end
  endtask

  // Build expectations for npat patterns; returns final signature
  task automatic model_run(input int npat, input int pushn, output logic [7:0] sig);
    logic [3:0] l;
    l   = SEED;
    sig = 8'h00;
    for (int i = 0; i < npat; i++) begin
      if (i < pushn) q_x.push_back(l);
      sig = ref_misr(sig, resp(y_mode, y_key, l));
      l   = ref_lfsr(l);
    end
  endtask

  task automatic run_test(input int n, input logic [7:0] exp_sig, input int mode, input logic [3:0] key);
    int          cnt;
    logic [7:0]  sig;
    logic [15:0] st;
    cnt    = (n == 0) ? 256 : n;
    y_mode = mode;
    y_key  = key;
    model_run(cnt, cnt, sig);
    st = {1'b0, 1'b1, (sig == exp_sig), 1'b0, 4'b0000, sig};
    q_status.push_back(st);
    q_lat.push_back(RESC + 3 * cnt);
    bus.To_BIST_reg = {8'(n), exp_sig};
    @(negedge clk_50MHz);
    bus.BIST_clk_en = 1'b1;
    repeat (5) @(negedge clk_50MHz);
    bus.To_BIST_reg = 16'($urandom);
    for (int i = 0; i < RESC + 3 * cnt + 20; i++) begin
      if (bus.From_BIST_reg[14]) break;
      @(negedge clk_50MHz);
    end
    tests++;
    if (!bus.From_BIST_reg[14]) begin fails++; $display("FAIL done_timeout: got %h required done", bus.From_BIST_reg); end
    tests++;
    if (q_x.size() != 0) begin fails++; $display("FAIL pulse_count: got %0d missing required 0", q_x.size()); end
    bus.BIST_clk_en = 1'b0;
    repeat (5) @(negedge clk_50MHz);
    tests++;
    if (bus.From_BIST_reg !== st) begin fails++; $display("FAIL status_hold: got %h required %h", bus.From_BIST_reg, st); end
    check_idle_outputs("idle_outputs");
  endtask

  initial begin
    logic [7:0] sig;
    int         pulses;
    bus.BIST_clk_en = 1'b0;
    bus.To_BIST_reg = 16'hA5C3;
    repeat (5) @(negedge clk_50MHz);
    check_idle_outputs("reset_outputs");
    tests++;
    if (bus.From_BIST_reg !== 16'h0000) begin fails++; $display("FAIL reset_status: got %h required 0000", bus.From_BIST_reg); end
    BIST_res = 1'b0;
    repeat (3) @(negedge clk_50MHz);

    run_test(3, 8'h04, 0, 4'h0);
    run_test(3, 8'h05, 0, 4'h0);
    run_test(0, 8'h00, 1, 4'h0);

    for (int r = 0; r < 6; r++) begin
      int m, n;
      logic [3:0] k;
      logic [7:0] e;
      m = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 24));
      k = 4'($urandom);
      y_mode = m; y_key = k;
      model_run(n, 0, e);
      if ($urandom_range(0, 1) == 0) e = 8'($urandom);
      run_test(n, e, m, k);
    end

    // Abort after the second pulse; only two patterns may be applied
    y_mode = 0; y_key = 4'h0;
    model_run(10, 2, sig);
    model_run(2, 0, sig);
    q_status.push_back({4'b0001, 4'b0000, sig});
    bus.To_BIST_reg = {8'd10, 8'h00};
    @(negedge clk_50MHz);
    bus.BIST_clk_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200 && pulses < 2; i++) begin
      @(negedge clk_50MHz);
      if (bus.BIST_to_logic_clk) pulses++;
    end
    bus.BIST_clk_en = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    check_idle_outputs("abort_outputs");
    tests++;
    if (bus.From_BIST_reg[15:12] !== 4'b0001) begin fails++; $display("FAIL abort_bits: got %b required 0001", bus.From_BIST_reg[15:12]); end
    repeat (20) @(negedge clk_50MHz);
    tests++;
    if (q_x.size() != 0 || q_status.size() != 0) begin
      fails++; $display("FAIL abort_queues: got %0d/%0d required 0/0", q_x.size(), q_status.size());
    end

    // Reset during CLK_HI, then a clean run from the seed
    y_mode = 0;
    model_run(5, 5, sig);
    bus.To_BIST_reg = {8'd5, 8'h00};
    @(negedge clk_50MHz);
    bus.BIST_clk_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_50MHz);
      if (bus.BIST_to_logic_clk) break;
    end
    BIST_res = 1'b1;
    @(negedge clk_50MHz);
    tests++;
    if (bus.BIST_to_logic_clk !== 1'b0) begin fails++; $display("FAIL res_clk: got %b required 0", bus.BIST_to_logic_clk); end
    tests++;
    if (bus.From_BIST_reg !== 16'h0000) begin fails++; $display("FAIL res_status: got %h required 0000", bus.From_BIST_reg); end
    q_x.delete();
    bus.BIST_clk_en = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    BIST_res = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    run_test(3, 8'h04, 0, 4'h0);

    repeat (5) @(negedge clk_50MHz);
    tests++;
    if (q_status.size() != 0 || q_lat.size() != 0) begin
      fails++; $display("FAIL leftover: got %0d/%0d required 0/0", q_status.size(), q_lat.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
